// File: rtl/conv_sequencer_pkg.sv
// conv_pkg: shared types and constants for the convolution control slice.
//   state_t  - sequencer states
//   TAPS/WIN - MAC taps per output and window edge length
//   *_W      - address, buffer-address, counter and cycle-counter widths
package conv_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LD_FILT,
        LD_ROWS,
        SHIFT,
        MAC,
        WR,
        NXT,
        DONE
    } state_t;

    localparam int TAPS   = 16;
    localparam int WIN    = 4;
    localparam int ADDR_W = 10;
    localparam int BUFF_W = 6;
    localparam int CNT_W  = 6;
    localparam int CYC_W  = 32;

endpackage

// File: rtl/conv_sequencer_if.sv
// conv_sequencer_if: start/done handshake plus every datapath strobe, counter
// and address driven by the convolution sequencer.
//   master - the side that issues start and consumes strobes (top level / bench)
//   slave  - the sequencer itself
// Optional: cycle_count exists only when CYC_CNT_EN is defined.
interface conv_sequencer_if;
    import conv_pkg::*;

    logic              start;
    logic              busy;
    logic              done;
    logic              wEnBuff;
    logic              w_r_EnMem;
    logic              wEnFilter;
    logic              writeEnwindow;
    logic              readEnmac;
    logic              addEn;
    logic              winRst;
    logic [CNT_W-1:0]  filterCount;
    logic [CNT_W-1:0]  macCount;
    logic [ADDR_W-1:0] memAddress;
    logic [BUFF_W-1:0] buffAddress;
`ifdef CYC_CNT_EN
    logic [CYC_W-1:0]  cycle_count;
`endif

    modport master (
        output start,
        input  busy, done, wEnBuff, w_r_EnMem, wEnFilter, writeEnwindow,
        input  readEnmac, addEn, winRst, filterCount, macCount,
        input  memAddress, buffAddress
`ifdef CYC_CNT_EN
        , input cycle_count
`endif
    );

    modport slave (
        input  start,
        output busy, done, wEnBuff, w_r_EnMem, wEnFilter, writeEnwindow,
        output readEnmac, addEn, winRst, filterCount, macCount,
        output memAddress, buffAddress
`ifdef CYC_CNT_EN
        , output cycle_count
`endif
    );

endinterface

// File: rtl/conv_sequencer_addr_gen.sv
// conv_addr_gen: step/row/column counters and memory/buffer address generation.
//   clk, rst      - clock, asynchronous active-high reset
//   state_q_i     - current sequencer state
//   state_d_i     - next sequencer state (counters react to transitions)
//   step_o        - cycle index within the current state
//   row_o, col_o  - current output row / column
//   mem_addr_o    - memory word address
//   buff_addr_o   - main buffer word address
module conv_addr_gen
    import conv_pkg::*;
#(
    parameter int                IMG_W     = 8,
    parameter logic [ADDR_W-1:0] FILT_BASE = 10'd0,
    parameter logic [ADDR_W-1:0] IMG_BASE  = 10'd4,
    parameter logic [ADDR_W-1:0] OUT_BASE  = 10'd512
) (
    input  logic              clk,
    input  logic              rst,
    input  state_t            state_q_i,
    input  state_t            state_d_i,
    output logic [CNT_W-1:0]  step_o,
    output logic [ADDR_W-1:0] row_o,
    output logic [CNT_W-1:0]  col_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [BUFF_W-1:0] buff_addr_o
);

    localparam logic [ADDR_W-1:0] WPR        = ADDR_W'(IMG_W / 4);
    localparam logic [ADDR_W-1:0] OUT_W      = ADDR_W'(IMG_W - 3);
    // Four rows of WPR words each is exactly IMG_W words.
    localparam logic [CNT_W-1:0]  ROW_WORDS  = CNT_W'(IMG_W);
    localparam logic [CNT_W-1:0]  FILT_WORDS = CNT_W'(TAPS / 4);

    logic [CNT_W-1:0]  step_q, step_d;
    logic [ADDR_W-1:0] row_q, row_d;
    logic [CNT_W-1:0]  col_q, col_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            step_q <= '0;
            row_q  <= '0;
            col_q  <= '0;
        end else begin
            step_q <= step_d;
            row_q  <= row_d;
            col_q  <= col_d;
        end
    end

    always_comb begin
        step_d = '0;
        if (state_d_i == state_q_i && state_q_i != IDLE)
            step_d = step_q + CNT_W'(1);

        col_d = col_q;
        if (state_q_i == LD_ROWS)
            col_d = '0;
        else if (state_q_i == NXT && state_d_i == SHIFT)
            col_d = col_q + CNT_W'(1);

        row_d = row_q;
        if (state_q_i == IDLE)
            row_d = '0;
        else if (state_q_i == NXT && state_d_i == LD_ROWS)
            row_d = row_q + ADDR_W'(1);
    end

    // Loads run one step past the last address: the final step only writes
    // the word returned for the previous address.
    always_comb begin
        mem_addr_o  = '0;
        buff_addr_o = '0;
        case (state_q_i)
            LD_FILT: begin
                if (step_q < FILT_WORDS)
                    mem_addr_o = FILT_BASE + ADDR_W'(step_q);
            end
            LD_ROWS: begin
                if (step_q < ROW_WORDS)
                    mem_addr_o = IMG_BASE + row_q * WPR + ADDR_W'(step_q);
                if (step_q != '0)
                    buff_addr_o = BUFF_W'(step_q - CNT_W'(1));
            end
            WR: mem_addr_o = OUT_BASE + row_q * OUT_W + ADDR_W'(col_q);
            default: ;
        endcase
    end

    assign step_o = step_q;
    assign row_o  = row_q;
    assign col_o  = col_q;

endmodule

// File: rtl/conv_sequencer.sv
// conv_sequencer: control FSM for the convolution datapath. Loads the 4x4
// filter, stages four image rows, slides the window column by column, runs a
// 16-tap MAC per output and writes each result back to memory.
//   clk  - clock
//   rst  - asynchronous active-high reset
//   bus  - conv_sequencer_if.slave: start/busy/done handshake and all
//          datapath strobes, counters and addresses
// Optional: define CYC_CNT_EN to add bus.cycle_count (busy-cycle counter).
module conv_sequencer
    import conv_pkg::*;
#(
    parameter int                IMG_W     = 8,
    parameter int                IMG_H     = 6,
    parameter logic [ADDR_W-1:0] FILT_BASE = 10'd0,
    parameter logic [ADDR_W-1:0] IMG_BASE  = 10'd4,
    parameter logic [ADDR_W-1:0] OUT_BASE  = 10'd512
) (
    input  logic             clk,
    input  logic             rst,
    conv_sequencer_if.slave  bus
);

    localparam logic [CNT_W-1:0]  FILT_LAST  = CNT_W'(TAPS / 4);
    localparam logic [CNT_W-1:0]  ROWS_LAST  = CNT_W'(IMG_W);
    localparam logic [CNT_W-1:0]  SHIFT_FULL = CNT_W'(WIN - 1);
    localparam logic [CNT_W-1:0]  MAC_LAST   = CNT_W'(TAPS - 1);
    localparam logic [CNT_W-1:0]  COL_LAST   = CNT_W'(IMG_W - 4);
    localparam logic [ADDR_W-1:0] ROW_LAST   = ADDR_W'(IMG_H - 4);

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  step;
    logic [ADDR_W-1:0] row;
    logic [CNT_W-1:0]  col;
    logic              busy_w;

    conv_addr_gen #(
        .IMG_W     (IMG_W),
        .FILT_BASE (FILT_BASE),
        .IMG_BASE  (IMG_BASE),
        .OUT_BASE  (OUT_BASE)
    ) u_addr (
        .clk         (clk),
        .rst         (rst),
        .state_q_i   (state_q),
        .state_d_i   (state_d),
        .step_o      (step),
        .row_o       (row),
        .col_o       (col),
        .mem_addr_o  (bus.memAddress),
        .buff_addr_o (bus.buffAddress)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    assign busy_w = (state_q != IDLE) && (state_q != DONE);

    always_comb begin
        state_d           = state_q;
        bus.busy          = busy_w;
        bus.done          = 1'b0;
        bus.wEnBuff       = 1'b0;
        bus.w_r_EnMem     = 1'b0;
        bus.wEnFilter     = 1'b0;
        bus.writeEnwindow = 1'b0;
        bus.readEnmac     = 1'b0;
        bus.addEn         = 1'b0;
        bus.winRst        = 1'b0;
        bus.filterCount   = '0;
        bus.macCount      = '0;
        case (state_q)
            IDLE: begin
                if (bus.start) state_d = LD_FILT;
            end
            LD_FILT: begin
                // Write lags the address by one cycle; each word holds 4 taps.
                if (step != '0) begin
                    bus.wEnFilter   = 1'b1;
                    bus.filterCount = (step - CNT_W'(1)) << 2;
                end
                if (step == FILT_LAST) state_d = LD_ROWS;
            end
            LD_ROWS: begin
                bus.wEnBuff = (step != '0);
                if (step == ROWS_LAST) state_d = SHIFT;
            end
            SHIFT: begin
                // First column fills the whole window; later ones shift in one.
                bus.writeEnwindow = 1'b1;
                if (step == ((col == '0) ? SHIFT_FULL : '0)) state_d = MAC;
            end
            MAC: begin
                bus.readEnmac   = 1'b1;
                bus.addEn       = 1'b1;
                bus.macCount    = step + CNT_W'(1);
                bus.filterCount = step;
                if (step == MAC_LAST) state_d = WR;
            end
            WR: begin
                bus.w_r_EnMem = 1'b1;
                state_d       = NXT;
            end
            NXT: begin
                bus.winRst = 1'b1;
                if (col < COL_LAST)      state_d = SHIFT;
                else if (row < ROW_LAST) state_d = LD_ROWS;
                else                     state_d = DONE;
            end
            DONE: begin
                bus.done = 1'b1;
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

`ifdef CYC_CNT_EN
    logic [CYC_W-1:0] cyc_q, cyc_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) cyc_q <= '0;
        else     cyc_q <= cyc_d;
    end

    always_comb begin
        cyc_d = cyc_q;
        if (state_q == IDLE && bus.start) cyc_d = '0;
        else if (busy_w)                  cyc_d = cyc_q + CYC_W'(1);
    end

    assign bus.cycle_count = cyc_q;
`endif

endmodule

// File: tb/tb_conv_sequencer.sv
`timescale 1ns/1ps
module tb_conv_sequencer;
    import conv_pkg::*;

    localparam int IMG_W = 8;
    localparam int IMG_H = 6;
    localparam int WPR   = IMG_W / 4;
    localparam int FB    = 0;
    localparam int IB    = 4;
    localparam int OB    = 512;
    localparam int N_OUT = (IMG_W - 3) * (IMG_H - 3);

    // {busy, done, wEnBuff, w_r_EnMem, wEnFilter, writeEnwindow, readEnmac,
    //  addEn, winRst, filterCount, macCount, memAddress, buffAddress}
    typedef logic [36:0] vec_t;

    logic clk = 1'b0;
    logic rst;
    int   n_cmp = 0;
    int   n_bad = 0;
    int   wr_seen = 0;
    vec_t exp_q[$];

    conv_sequencer_if bus();

    conv_sequencer #(
        .IMG_W     (IMG_W),
        .IMG_H     (IMG_H),
        .FILT_BASE (10'(FB)),
        .IMG_BASE  (10'(IB)),
        .OUT_BASE  (10'(OB))
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    function automatic vec_t mk(bit bsy, bit dn, bit wbuf, bit wmem, bit wfil,
                                bit wwin, bit ren, bit add, bit wrst,
                                int fc, int mc, int ma, int ba);
        vec_t v;
        v = {bsy, dn, wbuf, wmem, wfil, wwin, ren, add, wrst,
             6'(fc), 6'(mc), 10'(ma), 6'(ba)};
        return v;
    endfunction

    function automatic vec_t sample();
        vec_t v;
        v = {bus.busy, bus.done, bus.wEnBuff, bus.w_r_EnMem, bus.wEnFilter,
             bus.writeEnwindow, bus.readEnmac, bus.addEn, bus.winRst,
             bus.filterCount, bus.macCount, bus.memAddress, bus.buffAddress};
        return v;
    endfunction

    task automatic check(string name, vec_t act, vec_t exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s t=%0t got=%h expected=%h", name, $time, act, exp);
        end
    endtask

    task automatic check_int(string name, int act, int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s t=%0t got=%0d expected=%0d", name, $time, act, exp);
        end
    endtask

    // Expected per-cycle trace of one complete run, built from the operation
    // sequence: filter load, then per output row a 4-row load followed by one
    // shift/MAC/write/advance group per output column, then done.
    function automatic void gen_run();
        for (int i = 0; i <= TAPS / 4; i++)
            exp_q.push_back(mk(1, 0, 0, 0, i > 0, 0, 0, 0, 0,
                               (i > 0) ? (i - 1) * 4 : 0, 0,
                               (i < 4) ? FB + i : 0, 0));
        for (int r = 0; r <= IMG_H - 4; r++) begin
            for (int i = 0; i <= 4 * WPR; i++)
                exp_q.push_back(mk(1, 0, i > 0, 0, 0, 0, 0, 0, 0, 0, 0,
                                   (i < 4 * WPR) ? IB + r * WPR + i : 0,
                                   (i > 0) ? i - 1 : 0));
            for (int c = 0; c <= IMG_W - 4; c++) begin
                for (int s = 0; s < ((c == 0) ? WIN : 1); s++)
                    exp_q.push_back(mk(1, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0));
                for (int t = 1; t <= TAPS; t++)
                    exp_q.push_back(mk(1, 0, 0, 0, 0, 0, 1, 1, 0, t - 1, t, 0, 0));
                exp_q.push_back(mk(1, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0,
                                   OB + r * (IMG_W - 3) + c, 0));
                exp_q.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0));
            end
        end
        exp_q.push_back(mk(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    endfunction

    // Monitor: pops one expected vector per active DUT cycle.
    initial begin
        vec_t act;
        vec_t exp;
        forever begin
            @(negedge clk);
            act = sample();
            if (rst === 1'b1) begin
                exp_q.delete();
                wr_seen = 0;
                check("reset_outputs", act, '0);
            end else if (bus.busy === 1'b1 || bus.done === 1'b1) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_activity", act, '0);
                end else begin
                    exp = exp_q.pop_front();
                    check("cycle_trace", act, exp);
                end
                if (bus.w_r_EnMem === 1'b1) wr_seen++;
                if (bus.done === 1'b1) begin
                    check_int("write_count", wr_seen, N_OUT);
                    wr_seen = 0;
                end
            end else begin
                check("idle_outputs", act, '0);
            end
        end
    end

    task automatic do_start();
        @(posedge clk); #1;
        repeat ($urandom_range(0, 6)) begin
            @(posedge clk); #1;
        end
        bus.start = 1'b1;
        gen_run();
        @(posedge clk); #1;
        bus.start = 1'b0;
    endtask

    task automatic run_full(bit spur);
        int cyc;
        bit got;
        int sp1;
        int sp2;
        cyc = 0;
        got = 0;
        sp1 = $urandom_range(2, 150);
        sp2 = $urandom_range(151, 300);
        do_start();
        while (!got && cyc < 3000) begin
            bus.start = spur && (cyc == sp1 || cyc == sp2);
            if (bus.done === 1'b1) got = 1;
            else begin
                @(posedge clk); #1;
                cyc++;
            end
        end
        bus.start = 1'b0;
        if (!got) check_int("done_timeout", 0, 1);
        @(posedge clk); #1;
        check_int("queue_drained", exp_q.size(), 0);
    endtask

    task automatic run_abort();
        int cyc;
        int wr;
        int tap;
        bit hit;
        cyc = 0;
        wr  = 0;
        hit = 0;
        tap = $urandom_range(1, TAPS);
        do_start();
        while (!hit && cyc < 3000) begin
            if (bus.w_r_EnMem === 1'b1) wr++;
            if (wr == 2 && bus.macCount == 6'(tap)) hit = 1;
            else begin
                @(posedge clk); #1;
                cyc++;
            end
        end
        if (!hit) check_int("abort_point_timeout", 0, 1);
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        repeat (3) @(posedge clk);
        #1 check_int("abort_queue_flushed", exp_q.size(), 0);
    endtask

    initial begin
        rst       = 1'b1;
        bus.start = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        run_full(1'b0);
        run_full(1'b1);
        run_abort();
        run_full(1'b0);
        repeat (5) @(posedge clk);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
